// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the backing-memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DONE} arb_state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam int LINE_WORDS = 4;
  localparam int DATA_W_DEF = 32;

  function automatic int beat_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int offset_w(input int line_words, input int data_w);
    return $clog2(line_words * data_w / 8);
  endfunction

  localparam int BEAT_W   = beat_w(LINE_WORDS);
  localparam int OFFSET_W = offset_w(LINE_WORDS, DATA_W_DEF);

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; a tie goes to the side that was not served last.
module rr_arb2
  import mem_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   en,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   upd,
  input  owner_e upd_owner,
  output logic   gnt,
  output owner_e gnt_owner
);

  owner_e last_grant;

  always_ff @(posedge i_clk) begin
    if (i_reset)  last_grant <= OWN_I;
    else if (upd) last_grant <= upd_owner;
  end

  always_comb begin
    gnt = en && (req_i || req_d);
    if (req_i && req_d) gnt_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
    else if (req_d)     gnt_owner = OWN_D;
    else                gnt_owner = OWN_I;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache refill and D-cache refill/writeback,
// running fixed-length line bursts with round-robin arbitration on ties.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_WORDS = mem_pkg::LINE_WORDS
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_ic_req,
  input  logic [ADDR_W-1:0]               i_ic_addr,
  output logic                            o_ic_rvalid,
  output logic [DATA_W-1:0]               o_ic_rdata,
  output logic                            o_ic_done,
  input  logic                            i_dc_req,
  input  logic                            i_dc_we,
  input  logic [ADDR_W-1:0]               i_dc_addr,
  input  logic [DATA_W-1:0]               i_dc_wdata,
  output logic [beat_w(LINE_WORDS)-1:0]   o_dc_beat,
  output logic                            o_dc_rvalid,
  output logic [DATA_W-1:0]               o_dc_rdata,
  output logic                            o_dc_done,
  output logic                            o_mem_req,
  output logic                            o_mem_we,
  output logic [ADDR_W-1:0]               o_mem_addr,
  output logic [DATA_W-1:0]               o_mem_wdata,
  input  logic                            i_mem_ack,
  input  logic [DATA_W-1:0]               i_mem_rdata
);

  localparam int BW   = beat_w(LINE_WORDS);
  localparam int OW   = offset_w(LINE_WORDS, DATA_W);
  localparam int BYTE = $clog2(DATA_W / 8);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OW){1'b1}}, {OW{1'b0}}};

  arb_state_e        state_q, state_d;
  owner_e            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [BW-1:0]     beat_q;
  logic              gnt;
  owner_e            gnt_owner;

  rr_arb2 u_rr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .en        (state_q == IDLE),
    .req_i     (i_ic_req),
    .req_d     (i_dc_req),
    .upd       (state_q == DONE),
    .upd_owner (owner_q),
    .gnt       (gnt),
    .gnt_owner (gnt_owner)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt) state_d = BURST;
      BURST:   if (i_mem_ack && beat_q == LAST_BEAT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt) begin
        owner_q <= gnt_owner;
        // I-cache only ever refills, so its bursts are reads regardless of i_dc_we
        we_q    <= (gnt_owner == OWN_D) && i_dc_we;
        base_q  <= ((gnt_owner == OWN_D) ? i_dc_addr : i_ic_addr) & LINE_MASK;
        beat_q  <= '0;
      end else if (state_q == BURST && i_mem_ack) begin
        beat_q  <= beat_q + 1'b1;
      end
    end
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_ic_rvalid = 1'b0;
    o_ic_rdata  = '0;
    o_ic_done   = 1'b0;
    o_dc_rvalid = 1'b0;
    o_dc_rdata  = '0;
    o_dc_done   = 1'b0;
    o_dc_beat   = '0;
    if (state_q == BURST) begin
      o_mem_req   = 1'b1;
      o_mem_we    = we_q;
      o_mem_addr  = base_q | (ADDR_W'(beat_q) << BYTE);
      o_mem_wdata = i_dc_wdata;
      if (i_mem_ack && !we_q) begin
        if (owner_q == OWN_D) begin
          o_dc_rvalid = 1'b1;
          o_dc_rdata  = i_mem_rdata;
        end else begin
          o_ic_rvalid = 1'b1;
          o_ic_rdata  = i_mem_rdata;
        end
      end
    end
    if (state_q == DONE) begin
      o_ic_done = (owner_q == OWN_I);
      o_dc_done = (owner_q == OWN_D);
    end
    if (state_q != IDLE && owner_q == OWN_D) o_dc_beat = beat_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench: a line-level model predicts owner, beat addresses and data.
module tb_mem_arbiter;

  logic        i_clk, i_reset;
  logic        i_ic_req, i_dc_req, i_dc_we, i_mem_ack;
  logic [31:0] i_ic_addr, i_dc_addr, i_dc_wdata, i_mem_rdata;
  logic        o_ic_rvalid, o_ic_done, o_dc_rvalid, o_dc_done, o_mem_req, o_mem_we;
  logic [31:0] o_ic_rdata, o_dc_rdata, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_dc_beat;

  int          checks = 0, failures = 0;
  bit          last_d;
  logic [31:0] seed, wpat;

  mem_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr), .o_ic_rvalid(o_ic_rvalid),
    .o_ic_rdata(o_ic_rdata), .o_ic_done(o_ic_done),
    .i_dc_req(i_dc_req), .i_dc_we(i_dc_we), .i_dc_addr(i_dc_addr), .i_dc_wdata(i_dc_wdata),
    .o_dc_beat(o_dc_beat), .o_dc_rvalid(o_dc_rvalid), .o_dc_rdata(o_dc_rdata), .o_dc_done(o_dc_done),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // memory responder: read data is a scrambled copy of the word address
  task automatic drive(input bit ack);
    i_mem_ack   = ack;
    i_mem_rdata = ack ? (o_mem_addr ^ seed) : $urandom;
    i_dc_wdata  = wpat + 32'(o_dc_beat);
    #1;
  endtask

  function automatic bit pick_d(input bit ri, input bit rd);
    return (ri && rd) ? !last_d : rd;
  endfunction

  task automatic do_reset();
    i_reset = 1'b1;
    @(negedge i_clk);
    drive(0);
    chk("rst_ctl", {26'b0, o_ic_rvalid, o_ic_done, o_dc_rvalid, o_dc_done, o_mem_req, o_mem_we}, 32'h0);
    chk("rst_addr", o_mem_addr, 32'h0);
    chk("rst_wdata", o_mem_wdata, 32'h0);
    chk("rst_rdata", o_ic_rdata | o_dc_rdata, 32'h0);
    chk("rst_beat", 32'(o_dc_beat), 32'h0);
    i_reset = 1'b0;
    last_d  = 1'b0;
  endtask

  // One full line as seen from memory. mode: 0 zero-wait, 1 ack every 3rd cycle, 2 random.
  task automatic run_line(input bit own_d, input logic [31:0] addr, input bit we, input int mode,
                          input int exp_gap, input bit drop, input bit scramble);
    logic [31:0] base;
    int gap, k, cnt;
    bit ack;
    base = addr & ~32'hF;
    gap  = 0;
    drive(0);
    while (!o_mem_req && gap < 40) begin
      @(negedge i_clk);
      gap++;
      drive(0);
    end
    chk("grant", 32'(o_mem_req), 32'h1);
    if (exp_gap >= 0) chk("grant_gap", gap, exp_gap);
    k = 0; cnt = 0;
    while (k < 4 && cnt < 200) begin
      ack = (mode == 0) ? 1'b1 : (mode == 1) ? (cnt % 3 == 2) : ($urandom_range(0, 2) == 0);
      drive(ack);
      chk("beat_req", 32'(o_mem_req), 32'h1);
      chk("beat_addr", o_mem_addr, base + 32'(4 * k));
      chk("beat_we", 32'(o_mem_we), 32'(we));
      if (we) chk("beat_wdata", o_mem_wdata, wpat + 32'(k));
      chk("dc_beat", 32'(o_dc_beat), own_d ? 32'(k) : 32'h0);
      chk("ic_rvalid", 32'(o_ic_rvalid), 32'(ack && !we && !own_d));
      chk("dc_rvalid", 32'(o_dc_rvalid), 32'(ack && !we && own_d));
      if (ack && !we) chk("rdata", own_d ? o_dc_rdata : o_ic_rdata, (base + 32'(4 * k)) ^ seed);
      chk("early_done", 32'({o_ic_done, o_dc_done}), 32'h0);
      if (scramble && cnt == 0) begin
        if (own_d) begin i_dc_addr = $urandom; i_dc_we = 1'($urandom_range(0, 1)); end
        else i_ic_addr = $urandom;
      end
      if (ack) k++;
      cnt++;
      @(negedge i_clk);
    end
    drive(0);
    chk("ic_done", 32'(o_ic_done), 32'(!own_d));
    chk("dc_done", 32'(o_dc_done), 32'(own_d));
    chk("done_req", 32'({o_mem_req, o_ic_rvalid, o_dc_rvalid}), 32'h0);
    last_d = own_d;
    if (drop) begin
      if (own_d) i_dc_req = 1'b0;
      else       i_ic_req = 1'b0;
    end
    @(negedge i_clk);
  endtask

  initial begin
    bit od;
    int cnt;
    i_reset = 1'b1; i_ic_req = 0; i_dc_req = 0; i_dc_we = 0; i_mem_ack = 0;
    i_ic_addr = 0; i_dc_addr = 0; i_dc_wdata = 0; i_mem_rdata = 0;
    seed = 0; wpat = 0; last_d = 0;
    repeat (2) @(negedge i_clk);
    do_reset();

    // I-only read, data = address
    i_ic_addr = 32'h104; i_ic_req = 1;
    run_line(0, 32'h104, 0, 0, 1, 1, 0);

    // D writeback of 0xA0..0xA3
    i_dc_addr = 32'h2000; i_dc_we = 1; wpat = 32'hA0; i_dc_req = 1;
    run_line(1, 32'h2000, 1, 0, 1, 1, 0);

    // tie from reset, both held: D, I, D, I
    do_reset();
    seed = $urandom;
    i_ic_addr = 32'h1000; i_dc_addr = 32'h3004; i_dc_we = 0;
    i_ic_req = 1; i_dc_req = 1;
    run_line(1, 32'h3004, 0, 0, 1, 0, 0);
    run_line(0, 32'h1000, 0, 0, 1, 0, 0);
    run_line(1, 32'h3004, 0, 0, 1, 0, 0);
    run_line(0, 32'h1000, 0, 0, 1, 0, 0);
    i_ic_req = 0; i_dc_req = 0;
    @(negedge i_clk);

    // D read with memory acking every third cycle
    seed = $urandom;
    i_dc_addr = 32'h4008; i_dc_we = 0; i_dc_req = 1;
    run_line(1, 32'h4008, 0, 1, 1, 1, 0);

    // reset at beat 2 of an I read, then the re-request restarts at beat 0
    i_ic_addr = 32'h5A8; i_ic_req = 1;
    cnt = 0;
    drive(0);
    while (!o_mem_req && cnt < 10) begin @(negedge i_clk); cnt++; drive(0); end
    chk("mid_grant", 32'(o_mem_req), 32'h1);
    for (int k = 0; k < 2; k++) begin
      drive(1);
      chk("mid_addr", o_mem_addr, 32'h5A0 + 32'(4 * k));
      @(negedge i_clk);
    end
    drive(0);
    chk("mid_b2_addr", o_mem_addr, 32'h5A8);
    do_reset();
    run_line(0, 32'h5A8, 0, 0, 1, 1, 0);

    // D held through its done while I pends: D, I, D
    i_dc_addr = 32'h6000; i_dc_we = 0; i_ic_addr = 32'h7010;
    i_dc_req = 1; i_ic_req = 1;
    od = pick_d(1, 1);
    chk("fair_first", 32'(od), 32'h1);
    run_line(1, 32'h6000, 0, 2, 1, 0, 0);
    run_line(0, 32'h7010, 0, 0, 1, 1, 0);
    run_line(1, 32'h6000, 0, 0, 1, 1, 0);

    // randomized traffic against the line model
    for (int n = 0; n < 14; n++) begin
      if (!i_ic_req && $urandom_range(0, 1) == 1) begin i_ic_addr = $urandom; i_ic_req = 1; end
      if (!i_dc_req && $urandom_range(0, 1) == 1) begin
        i_dc_addr = $urandom; i_dc_we = 1'($urandom_range(0, 1)); i_dc_req = 1;
      end
      if (!i_ic_req && !i_dc_req) begin i_ic_addr = $urandom; i_ic_req = 1; end
      wpat = $urandom; seed = $urandom;
      od = pick_d(i_ic_req, i_dc_req);
      run_line(od, od ? i_dc_addr : i_ic_addr, od ? i_dc_we : 1'b0,
               int'($urandom_range(0, 2)), 1, 1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the pipelined core.
- Grants one requester at a time and runs a fixed-length line burst, one word per memory beat.
- Streams read data back to the granted cache, or pulls write data from it.
- Uses round-robin fairness when both caches miss together, so neither pipeline side starves.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory word width.
- LINE_WORDS, 4, words per cache line; must be a power of two, ≥2.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_ic_req  in  1  I-cache line-read request; level, held until o_ic_done.
- i_ic_addr  in  ADDR_W  I-cache miss address.
- o_ic_rvalid  out  1  beat of read data valid for the I-cache.
- o_ic_rdata  out  DATA_W  read word.
- o_ic_done  out  1  one-cycle pulse, line complete.
- i_dc_req  in  1  D-cache request; level, held until o_dc_done.
- i_dc_we  in  1  1 = line writeback, 0 = line read; sampled at grant.
- i_dc_addr  in  ADDR_W  D-cache line address.
- i_dc_wdata  in  DATA_W  write word for the beat on o_dc_beat; combinational.
- o_dc_beat  out  log2(LINE_WORDS)  current beat index.
- o_dc_rvalid  out  1  read beat valid for the D-cache.
- o_dc_rdata  out  DATA_W  read word.
- o_dc_done  out  1  one-cycle pulse, line complete.
- o_mem_req  out  1  memory beat request.
- o_mem_we  out  1  write beat.
- o_mem_addr  out  ADDR_W  word address of the beat.
- o_mem_wdata  out  DATA_W  write data.
- i_mem_ack  in  1  beat accepted; on reads, i_mem_rdata is valid this cycle.
- i_mem_rdata  in  DATA_W  read data.

Behaviour:
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - Arbitrate when any request is high.
  - Only one requester high → grant it.
  - Both high → grant the side opposite last_grant (1-bit register, reset value = I, so the first tie goes to D).
  - On grant: latch owner, latch we (forced 0 for I), latch base address with the low log2(LINE_WORDS*DATA_W/8) bits zeroed, clear beat counter → BURST.
  - Grant-to-first-o_mem_req latency is 1 cycle.
- BURST:
  - o_mem_req = 1.
  - o_mem_addr = base + beat*(DATA_W/8).
  - o_mem_we = latched we.
  - o_mem_wdata = i_dc_wdata.
  - Hold address and data stable until i_mem_ack.
  - On ack with read: assert owner's rvalid with rdata = i_mem_rdata in the same cycle (combinational pass-through).
  - On ack: beat increments.
  - On ack of beat LINE_WORDS-1 → DONE; o_mem_req deasserts the next cycle.
  - Back-to-back acks give one beat per cycle.
- DONE:
  - Pulse the owner's done for 1 cycle and update last_grant = owner → IDLE.
  - The requester drops its req on seeing done; a req still high in the next IDLE cycle is treated as a new request.
- Non-owner ports:
  - rvalid and done stay 0.
  - o_dc_beat shows the counter only while D owns the port, otherwise 0.
- Requests raised during BURST/DONE wait; a request dropped before its done is ignored (no abort).
- Address or we changes after grant have no effect.
- Reset mid-burst:
  - Next cycle state = IDLE, beat = 0, last_grant = I.
  - All outputs 0; the burst is abandoned with no done pulse.
- Reset values: every output 0.
- Beat counter wraps naturally; no overflow beyond LINE_WORDS-1 since the FSM exits.
- Throughput: a line burst with zero-wait memory takes LINE_WORDS+2 cycles from grant to the next possible grant.

Decomposition:
- Shared package (the existing pipeline package, or a new mem_pkg):
  - arb_state_e enum {IDLE, BURST, DONE}.
  - owner_e enum {OWN_I, OWN_D}.
  - LINE_WORDS default, plus derived BEAT_W and OFFSET_W localparams.
- One sub-module, rr_arb2: a two-requester round-robin picker holding last_grant, with a grant-enable input and an update strobe.
- Everything else is inline: FSM, address/beat datapath, output muxing.

Test Plan:
- I-only read: i_ic_req=1, i_ic_addr=0x104, zero-wait memory returning addr-as-data.
  - Expect o_mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - Four o_ic_rvalid beats with matching data.
  - o_ic_done exactly one cycle after the last ack.
- D writeback: i_dc_we=1, addr 0x2000, wdata = 0xA0+beat.
  - Expect four writes of 0xA0..0xA3 to 0x2000..0x200C.
  - No rvalid on either side; o_dc_done pulse.
- Simultaneous requests from reset, then both held: grant order D, I, D, I.
  - Each grant follows the previous done with one IDLE cycle in between.
- Memory stalls: ack every 3rd cycle during a D read.
  - o_mem_addr and o_mem_req stay stable across stalls.
  - Exactly four rvalid beats; done after the 4th ack.
- Reset asserted at beat 2 of an I read.
  - Next cycle: all outputs 0, no o_ic_done.
  - Re-request after reset restarts at beat 0 of the aligned address.
- D request held high through its done while I is pending: I is granted next (fairness), then D again.
